// File: rtl/uart_rx.sv
// uart_rx: receive half of UART0. Deserializes 8N1 frames from rx into a
// first-word-fall-through receive FIFO, flags framing/overrun errors and
// drives the level interrupt for the UART0 RX trap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line idle, waiting for a falling edge on rx_s
//   START   | counting to mid start bit; high there means glitch
//   DATA    | sampling 8 data bits at mid-bit, LSB first
//   STOP    | sampling the stop bit; high pushes the byte, low is a frame error
//   WAIT_HI | break/framing recovery, waiting for the line to return high
module uart_rx #(
   parameter int CLK_FREQ   = 10_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             rx,
   input  logic                             rd_en,
   output logic [7:0]                       rd_data,
   output logic                             rd_valid,
   output logic                             fifo_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   input  logic                             err_clr,
   output logic                             frame_err,
   output logic                             overrun_err,
   output logic                             busy,
   output logic                             rx_irq
);

   localparam int BIT_CYC  = CLK_FREQ / BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CNT_W    = $clog2(BIT_CYC + 1);
   localparam int CNT_FW   = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_WAIT_HI = 3'd4
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;

   logic              rx_m;
   logic              rx_s;
   logic              rx_d;
   logic              rx_fall;
   logic              cnt_zero;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_FW-1:0] count;

   logic              push;
   logic              pop;
   logic              full;
   logic              do_wr;
   logic              overrun_set;
   logic              frame_set;

   // Two-flop synchronizer plus a registered copy for edge detection; idle line is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign rx_fall  = rx_d & ~rx_s;
   assign cnt_zero = (cnt == '0);

   // Frame FSM: mid-bit sampling driven by a down-counter reloaded per bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_fall) begin
                  cnt   <= CNT_W'(HALF_CYC - 1);
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_zero) begin
                  if (!rx_s) begin
                     cnt     <= CNT_W'(BIT_CYC - 1);
                     bit_idx <= '0;
                     state   <= ST_DATA;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_zero) begin
                  shreg <= {rx_s, shreg[7:1]};
                  cnt   <= CNT_W'(BIT_CYC - 1);
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_zero) begin
                  state <= rx_s ? ST_IDLE : ST_WAIT_HI;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WAIT_HI: begin
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A full FIFO still accepts the new byte when the head is popped in the same cycle.
   assign push        = (state == ST_STOP) && cnt_zero && rx_s;
   assign frame_set   = (state == ST_STOP) && cnt_zero && !rx_s;
   assign full        = (count == CNT_FW'(FIFO_DEPTH));
   assign pop         = rd_en && (count != '0);
   assign do_wr       = push && (!full || pop);
   assign overrun_set = push && full && !pop;

   // FIFO storage; contents need no reset because the count gates visibility.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= shreg;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new event in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (frame_set) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
         if (overrun_set) begin
            overrun_err <= 1'b1;
         end else if (err_clr) begin
            overrun_err <= 1'b0;
         end
      end
   end

   assign rd_valid   = (count != '0);
   assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_full  = full;
   assign fifo_count = count;
   assign busy       = (state != ST_IDLE);
   assign rx_irq     = rd_valid;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit; expected bytes are queued as
// frames are driven and compared when the FIFO head is read.
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       fifo_full;
   logic [3:0] fifo_count;
   logic       err_clr;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;
   logic       rx_irq;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];

   uart_rx #(
      .CLK_FREQ   (1_000_000),
      .BAUD       (100_000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .fifo_full   (fifo_full),
      .fifo_count  (fifo_count),
      .err_clr     (err_clr),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .busy        (busy),
      .rx_irq      (rx_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one frame starting at a negedge; stop level/length are selectable
   // and rd_en can be pulsed at negedge index pop_at (compared against the head).
   task automatic send_frame(input logic [7:0] data, input logic stop_val,
                             input int stop_len, input int pop_at);
      logic [9:0] bits;
      logic [7:0] e;
      int j;
      bits = {stop_val, data, 1'b0};
      j = 0;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < ((b == 9) ? stop_len : 10); c++) begin
            rx    = bits[b];
            rd_en = (j == pop_at);
            if (j == pop_at) begin
               e = exp_q.pop_front();
               n_tests++;
               if (rd_data !== e) begin
                  n_fail++;
                  $display("FAIL pop_in_frame rd_data got %h exp %h", rd_data, e);
               end
            end
            @(negedge clk);
            j++;
         end
      end
      rx    = 1'b1;
      rd_en = 1'b0;
   endtask

   task automatic read_byte(input string tag);
      logic [7:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         n_fail++;
         $display("FAIL %s valid=%b rd_data got %h exp %h", tag, rd_valid, rd_data, e);
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({rd_valid, rd_data, fifo_full, fifo_count, frame_err, overrun_err, busy, rx_irq} !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b exp 0",
                  {rd_valid, rd_data, fifo_full, fifo_count, frame_err, overrun_err, busy, rx_irq});
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single_byte();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 10, -1);
      n_tests++;
      if (fifo_count !== 4'd1 || rx_irq !== 1'b1 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin
         n_fail++;
         $display("FAIL a5_status count=%0d irq=%b fe=%b oe=%b exp 1 1 0 0",
                  fifo_count, rx_irq, frame_err, overrun_err);
      end
      read_byte("a5_data");
      n_tests++;
      if (rd_valid !== 1'b0 || rx_irq !== 1'b0 || rd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL a5_after_pop valid=%b irq=%b data=%h exp 0 0 00", rd_valid, rx_irq, rd_data);
      end
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_busy got %b exp 1", busy);
      end
      repeat (10) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || fifo_count !== 4'd0 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_idle busy=%b count=%0d fe=%b exp 0 0 0", busy, fifo_count, frame_err);
      end
   endtask

   task automatic test_frame_error();
      fork
         send_frame(8'h3C, 1'b0, 30, -1);
         begin
            repeat (110) @(negedge clk);
            n_tests++;
            if (frame_err !== 1'b1 || busy !== 1'b1 || fifo_count !== 4'd0) begin
               n_fail++;
               $display("FAIL frame_err_hold fe=%b busy=%b count=%0d exp 1 1 0", frame_err, busy, fifo_count);
            end
         end
      join
      repeat (10) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_hi_exit busy got %b exp 0", busy);
      end
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 10, -1);
      read_byte("after_fe_data");
      n_tests++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_err_sticky got %b exp 1", frame_err);
      end
      pulse_err_clr();
      n_tests++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_err_clr got %b exp 0", frame_err);
      end
   endtask

   task automatic test_overrun();
      logic exp_ovr;
      exp_ovr = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (exp_q.size() < 8) exp_q.push_back(8'(i));
         else exp_ovr = 1'b1;
         send_frame(8'(i), 1'b1, 10, -1);
      end
      n_tests++;
      if (fifo_full !== 1'b1 || fifo_count !== 4'(exp_q.size()) || overrun_err !== exp_ovr) begin
         n_fail++;
         $display("FAIL overrun_status full=%b count=%0d oe=%b exp 1 %0d %b",
                  fifo_full, fifo_count, overrun_err, exp_q.size(), exp_ovr);
      end
      for (int i = 0; i < 8; i++) read_byte("overrun_drain");
      n_tests++;
      if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
         n_fail++;
         $display("FAIL overrun_empty valid=%b count=%0d exp 0 0", rd_valid, fifo_count);
      end
      pulse_err_clr();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(8'h20 + 8'(i));
         send_frame(8'h20 + 8'(i), 1'b1, 10, -1);
      end
      n_tests++;
      if (fifo_full !== 1'b1 || overrun_err !== 1'b0) begin
         n_fail++;
         $display("FAIL refill full=%b oe=%b exp 1 0", fifo_full, overrun_err);
      end
      // Stop bit is sampled at the 98th clock edge after the start-bit drive.
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 10, 97);
      n_tests++;
      if (overrun_err !== 1'b0 || fifo_count !== 4'd8 || fifo_full !== 1'b1) begin
         n_fail++;
         $display("FAIL push_pop_full oe=%b count=%0d full=%b exp 0 8 1", overrun_err, fifo_count, fifo_full);
      end
      for (int i = 0; i < 8; i++) read_byte("b2b_drain");
   endtask

   task automatic test_reset_mid_frame();
      exp_q.push_back(8'h99);
      send_frame(8'h99, 1'b1, 10, -1);
      rx = 1'b0;
      repeat (55) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || fifo_count !== 4'd1) begin
         n_fail++;
         $display("FAIL pre_reset busy=%b count=%0d exp 1 1", busy, fifo_count);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({rd_valid, rd_data, fifo_full, fifo_count, frame_err, overrun_err, busy, rx_irq} !== 17'd0) begin
         n_fail++;
         $display("FAIL mid_frame_reset got %b exp 0",
                  {rd_valid, rd_data, fifo_full, fifo_count, frame_err, overrun_err, busy, rx_irq});
      end
      exp_q.delete();
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 10, -1);
      n_tests++;
      if (fifo_count !== 4'd1) begin
         n_fail++;
         $display("FAIL post_reset_count got %0d exp 1", fifo_count);
      end
      read_byte("post_reset_data");
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
